// File: rtl/decoder3to8_seq.sv
// decoder3to8_seq: sequenced 3-to-8 decoder.
//
// Codes arrive over a valid/ready handshake and are buffered in a small FIFO.
// Each code is then replayed as a one-hot byte. The byte is held for HOLD
// cycles and followed by GAP all-zero cycles, which gives downstream one-hot
// consumers stretched and separated pulses.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   code_in     3-bit code to decode (bit 2 is MSB)
//   code_valid  code_in is valid this cycle
//   code_ready  FIFO can accept (not full and not just out of reset)
//   o           registered one-hot word, zero when idle or in gap
//   o_valid     o carries a decoded word
//   busy        FIFO non-empty or sequencer not idle
//   word_count  saturating count of words that completed their hold time
module decoder3to8_seq #(
  parameter int HOLD  = 4,  // 1..255
  parameter int GAP   = 1,  // 0..255
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  code_in,
  input  logic        code_valid,
  output logic        code_ready,
  output logic [7:0]  o,
  output logic        o_valid,
  output logic        busy,
  output logic [15:0] word_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // Counter preload values. The counter counts down to zero, so a phase of
  // N cycles is loaded with N-1.
  localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LD  = 8'((GAP > 0) ? GAP - 1 : 0);

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          rst_q;
  logic          push, pop, fifo_empty;
  logic [2:0]    head;

  assign fifo_empty = (occ_q == '0);
  // Occupancy never exceeds DEPTH = 2**AW, so its MSB alone signals full.
  assign code_ready = ~occ_q[AW] & ~rst_q;
  assign push       = code_valid & code_ready;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: storage has no reset; the pointers and the occupancy count define
  // which entries are live, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= code_in;
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  o_q, o_d;
  logic        o_valid_q, o_valid_d;
  logic [15:0] wc_q, wc_d;
  logic        start_word;

  // NOTE: every signal written here gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    o_d        = o_q;
    o_valid_d  = o_valid_q;
    wc_d       = wc_q;
    start_word = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_d       = 8'h00;
        o_valid_d = 1'b0;
        start_word = ~fifo_empty;
      end

      S_DRIVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          if (wc_q != 16'hFFFF) wc_d = wc_q + 16'd1;
          if (GAP > 0) begin
            o_d       = 8'h00;
            o_valid_d = 1'b0;
            cnt_d     = GAP_LD;
            state_d   = S_GAP;
          end else if (!fifo_empty) begin
            // Back-to-back words: reload directly with no zero cycle.
            start_word = 1'b1;
          end else begin
            o_d       = 8'h00;
            o_valid_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end

      S_GAP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!fifo_empty) begin
          start_word = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = 8'd0;
        o_d       = 8'h00;
        o_valid_d = 1'b0;
      end
    endcase

    if (start_word) begin
      o_d       = 8'd1 << head;
      o_valid_d = 1'b1;
      cnt_d     = HOLD_LD;
      state_d   = S_DRIVE;
    end
  end

  assign pop = start_word;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples its pre-edge inputs, whatever the order of the statements.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      o_q       <= 8'h00;
      o_valid_q <= 1'b0;
      wc_q      <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      wc_q      <= wc_d;
    end
  end

  assign o          = o_q;
  assign o_valid    = o_valid_q;
  assign word_count = wc_q;
  assign busy       = ~fifo_empty | (state_q != S_IDLE);

endmodule

// File: tb/tb_decoder3to8_seq.sv
// Testbench for decoder3to8_seq. It drives two instances from one clock:
//   inst 0: HOLD=4 GAP=1 (defaults), inst 1: HOLD=1 GAP=0.
// The reference model schedules words by their start edge. A word accepted
// at edge a starts at max(a+1, previous_start + HOLD + GAP). All outputs are
// then derived from those start edges with plain arithmetic.
module tb_decoder3to8_seq;

  localparam int H0 = 4, G0 = 1, H1 = 1, G1 = 0, D = 4, RING = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld  [2];
  logic [2:0]  cin  [2];
  logic        rdy  [2];
  logic [7:0]  o_w  [2];
  logic        ov   [2];
  logic        bz   [2];
  logic [15:0] wc_w [2];

  always #5 clk = ~clk;

  decoder3to8_seq #(.HOLD(H0), .GAP(G0), .DEPTH(D)) dut0 (
    .clk(clk), .rst(rst), .code_in(cin[0]), .code_valid(vld[0]),
    .code_ready(rdy[0]), .o(o_w[0]), .o_valid(ov[0]), .busy(bz[0]),
    .word_count(wc_w[0])
  );

  decoder3to8_seq #(.HOLD(H1), .GAP(G1), .DEPTH(D)) dut1 (
    .clk(clk), .rst(rst), .code_in(cin[1]), .code_valid(vld[1]),
    .code_ready(rdy[1]), .o(o_w[1]), .o_valid(ov[1]), .busy(bz[1]),
    .word_count(wc_w[1])
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint t = 0;      // index of the most recent rising edge
  bit     quiet = 0;  // suppress per-cycle model comparisons (long runs)

  // Reference model state, one set per instance.
  int         n_acc [2];
  int         n_cmp [2];
  int         wc_m  [2];
  longint     last_s[2];
  longint     acc_e [2][RING];
  longint     st_e  [2][RING];
  logic [2:0] cd    [2][RING];
  logic       rdy_m [2];
  bit         acc_flag[2];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int hp(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int gp(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  // Apply edge t to the model of instance i, then compare the DUT outputs.
  task automatic model_edge(input int i);
    logic [7:0] eo;
    logic       ev, nonidle;
    int         occ, lo, idx;
    longint     s;
    eo = 8'h00; ev = 1'b0; nonidle = 1'b0; occ = 0;
    acc_flag[i] = 0;
    if (rst) begin
      n_acc[i]  = 0;
      n_cmp[i]  = 0;
      wc_m[i]   = 0;
      last_s[i] = -1000;
      rdy_m[i]  = 1'b0;
    end else begin
      if (vld[i] && rdy_m[i]) begin
        idx = n_acc[i] % RING;
        s = (t + 1 > last_s[i] + hp(i) + gp(i)) ? t + 1
                                                : last_s[i] + hp(i) + gp(i);
        acc_e[i][idx] = t;
        st_e[i][idx]  = s;
        cd[i][idx]    = cin[i];
        last_s[i]     = s;
        n_acc[i]++;
        acc_flag[i] = 1;
      end
      while (n_cmp[i] < n_acc[i] &&
             st_e[i][n_cmp[i] % RING] + hp(i) <= t) begin
        n_cmp[i]++;
        if (wc_m[i] < 65535) wc_m[i]++;
      end
      lo = (n_acc[i] > RING) ? n_acc[i] - RING : 0;
      for (int k = lo; k < n_acc[i]; k++) begin
        idx = k % RING;
        if (acc_e[i][idx] <= t && st_e[i][idx] > t) occ++;
        if (st_e[i][idx] <= t && t < st_e[i][idx] + hp(i)) begin
          eo = 8'd1 << cd[i][idx];
          ev = 1'b1;
        end
        if (st_e[i][idx] <= t && t < st_e[i][idx] + hp(i) + gp(i))
          nonidle = 1'b1;
      end
      rdy_m[i] = (occ < D);
    end
    if (!quiet) begin
      check($sformatf("i%0d o @%0d", i, t),          32'(o_w[i]),  32'(eo));
      check($sformatf("i%0d o_valid @%0d", i, t),    32'(ov[i]),   32'(ev));
      check($sformatf("i%0d busy @%0d", i, t),       32'(bz[i]),
            32'(occ > 0 || nonidle));
      check($sformatf("i%0d word_count @%0d", i, t), 32'(wc_w[i]), wc_m[i]);
      check($sformatf("i%0d code_ready @%0d", i, t), 32'(rdy[i]),  32'(rdy_m[i]));
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
    model_edge(0);
    model_edge(1);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Present a code on instance i and wait, within a bounded number of
  // cycles, until it is accepted. Valid is left high for back-to-back use.
  task automatic push(input int i, input logic [2:0] c);
    vld[i] = 1'b1;
    cin[i] = c;
    for (int k = 0; k < 100; k++) begin
      step();
      if (acc_flag[i]) break;
    end
    check($sformatf("i%0d push accepted code %0d", i, c),
          32'(acc_flag[i]), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    vld = '{1'b0, 1'b0};
    cin = '{3'd0, 3'd0};
    rdy_m = '{1'b0, 1'b0};
    idle(3);
    rst = 1'b0;
    idle(2);

    // Single decode on defaults: code 6 is 0x40 for 4 edges, then 0x00.
    push(0, 3'd6);
    vld[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("single o at N+%0d", k), 32'(o_w[0]), 32'h40);
    end
    step();
    check("single o at N+5", 32'(o_w[0]), 32'h00);
    idle(3);
    check("single word_count", 32'(wc_w[0]), 32'd1);
    check("single busy idle", 32'(bz[0]), 32'd0);

    // Reset held for 3 cycles while code 5 is being driven.
    push(0, 3'd5);
    vld[0] = 1'b0;
    idle(2);
    check("pre-reset o", 32'(o_w[0]), 32'h20);
    rst = 1'b1;
    idle(3);
    check("reset o",          32'(o_w[0]),  32'h00);
    check("reset o_valid",    32'(ov[0]),   32'd0);
    check("reset busy",       32'(bz[0]),   32'd0);
    check("reset word_count", 32'(wc_w[0]), 32'd0);
    check("reset code_ready", 32'(rdy[0]),  32'd0);
    rst = 1'b0;
    step();
    check("post-reset code_ready", 32'(rdy[0]), 32'd1);

    // Full sweep of codes 0..7 with valid held; the FIFO fills and stalls.
    for (int c = 0; c < 8; c++) push(0, 3'(c));
    vld[0] = 1'b0;
    idle(60);
    check("sweep word_count", 32'(wc_w[0]), 32'd8);

    // HOLD=1 GAP=0: 3,3,7 must appear on consecutive cycles.
    push(1, 3'd3);
    push(1, 3'd3);
    push(1, 3'd7);
    vld[1] = 1'b0;
    idle(6);
    check("gap0 word_count", 32'(wc_w[1]), 32'd3);

    // Full FIFO with simultaneous push/pop: valid held, new code per accept.
    vld[0] = 1'b1;
    cin[0] = 3'($urandom_range(0, 7));
    for (int k = 0; k < 60; k++) begin
      step();
      if (acc_flag[0]) cin[0] = 3'($urandom_range(0, 7));
    end
    vld[0] = 1'b0;
    idle(30);

    // Random traffic on both instances, with a reset pulse in the middle.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (acc_flag[i] || !vld[i]) begin
          vld[i] = ($urandom_range(0, 1) == 1);
          cin[i] = 3'($urandom_range(0, 7));
        end
      end
      rst = (k >= 200 && k < 202);
      step();
    end
    rst = 1'b0;
    vld = '{1'b0, 1'b0};
    idle(40);

    // Saturation: more than 65535 words on the HOLD=1 GAP=0 instance.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    quiet = 1;
    vld[1] = 1'b1;
    cin[1] = 3'd2;
    idle(65560);
    quiet = 0;
    vld[1] = 1'b0;
    idle(4);
    check("saturated word_count", 32'(wc_w[1]), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
